// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and data-memory wait
// stalls, with a saturating stall counter and a sticky memory-wait timeout flag.
`timescale 1ns/1ps
module hazard_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  IF_ID_rs_i,
  input  logic [4:0]  IF_ID_rt_i,
  input  logic [4:0]  ID_EX_rt_i,
  input  logic        ID_EX_memread_i,
  input  logic        branch_taken_i,
  input  logic        dmem_req_i,
  input  logic        dmem_ack_i,
  output logic        pc_write_o,
  output logic        IF_ID_write_o,
  output logic        IF_ID_flush_o,
  output logic        ID_EX_bubble_o,
  output logic        pipe_stall_o,
  output logic [15:0] stall_cnt_o,
  output logic        timeout_o,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    MEM_WAIT   = 2'b10
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  wait_cnt;
  logic [15:0] stall_cnt;
  logic        timeout;
  logic        luh;
  logic        miss;

  // Register zero never carries a real dependency, so a load into it never stalls.
  always_comb begin
    luh  = ID_EX_memread_i && (ID_EX_rt_i != 5'd0) &&
           ((ID_EX_rt_i == IF_ID_rs_i) || (ID_EX_rt_i == IF_ID_rt_i));
    miss = dmem_req_i && !dmem_ack_i;
  end

  // Memory handshake: an access is requested with dmem_req_i and completes in the
  // cycle dmem_ack_i is high; req and ack together is a hit and costs nothing.
  // Once waiting, only dmem_ack_i matters.
  always_comb begin
    pc_write_o     = 1'b1;
    IF_ID_write_o  = 1'b1;
    IF_ID_flush_o  = 1'b0;
    ID_EX_bubble_o = 1'b0;
    pipe_stall_o   = 1'b0;
    state_next     = state;
    case (state)
      RUN, LOAD_STALL: begin
        if (miss) begin
          pipe_stall_o  = 1'b1;
          pc_write_o    = 1'b0;
          IF_ID_write_o = 1'b0;
          state_next    = MEM_WAIT;
        end else if (luh && (state == RUN)) begin
          // A concurrent taken branch is not flushed: it re-resolves next cycle.
          pc_write_o     = 1'b0;
          IF_ID_write_o  = 1'b0;
          ID_EX_bubble_o = 1'b1;
          state_next     = LOAD_STALL;
        end else begin
          IF_ID_flush_o = branch_taken_i;
          state_next    = RUN;
        end
      end
      MEM_WAIT: begin
        if (!dmem_ack_i) begin
          pipe_stall_o  = 1'b1;
          pc_write_o    = 1'b0;
          IF_ID_write_o = 1'b0;
        end else begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= RUN;
      stall_cnt <= 16'd0;
      wait_cnt  <= 8'd0;
      timeout   <= 1'b0;
    end else begin
      state <= state_next;
      if (!pc_write_o && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      if ((state != MEM_WAIT) && (state_next == MEM_WAIT))
        wait_cnt <= 8'd0;
      else if ((state == MEM_WAIT) && (wait_cnt != 8'hFF))
        wait_cnt <= wait_cnt + 8'd1;
      // Flag rises on the edge where the wait counter reaches 255.
      if ((state == MEM_WAIT) && (wait_cnt == 8'hFE))
        timeout <= 1'b1;
    end
  end

  always_comb begin
    stall_cnt_o = stall_cnt;
    timeout_o   = timeout;
    state_o     = state;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: inputs change on the falling edge and
// combinational outputs are sampled shortly afterwards, away from the rising edge.
`timescale 1ns/1ps
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  if_id_rs;
  logic [4:0]  if_id_rt;
  logic [4:0]  id_ex_rt;
  logic        id_ex_memread;
  logic        branch_taken;
  logic        dmem_req;
  logic        dmem_ack;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic        pipe_stall;
  logic [15:0] stall_cnt;
  logic        timeout;
  logic [1:0]  state;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_cnt;

  // clock/reset block
  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .IF_ID_rs_i      (if_id_rs),
    .IF_ID_rt_i      (if_id_rt),
    .ID_EX_rt_i      (id_ex_rt),
    .ID_EX_memread_i (id_ex_memread),
    .branch_taken_i  (branch_taken),
    .dmem_req_i      (dmem_req),
    .dmem_ack_i      (dmem_ack),
    .pc_write_o      (pc_write),
    .IF_ID_write_o   (if_id_write),
    .IF_ID_flush_o   (if_id_flush),
    .ID_EX_bubble_o  (id_ex_bubble),
    .pipe_stall_o    (pipe_stall),
    .stall_cnt_o     (stall_cnt),
    .timeout_o       (timeout),
    .state_o         (state)
  );

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ex_rt,
                       input logic mr, input logic br, input logic req, input logic ack);
    if_id_rs      = rs;
    if_id_rt      = rt;
    id_ex_rt      = ex_rt;
    id_ex_memread = mr;
    branch_taken  = br;
    dmem_req      = req;
    dmem_ack      = ack;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // outputs packed as {pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_stall}
  task automatic chk_outs(input string tag, input logic [4:0] exp);
    chk(tag, {11'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_stall}, {11'd0, exp});
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("reset_state", 16'(state), 16'd0);
    chk("reset_cnt", stall_cnt, 16'd0);
    chk("reset_timeout", 16'(timeout), 16'd0);
    chk_outs("reset_outs", 5'b11000);
    @(negedge clk);
    rst = 1'b0;

    // load-use on rs: one bubble, then back to RUN
    drive(5, 0, 5, 1, 0, 0, 0);
    #1 chk_outs("luh_c1", 5'b00010);
    @(negedge clk);
    #1 chk("luh_state", 16'(state), 16'd1);
    chk_outs("luh_c2", 5'b11000);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1 chk("luh_back", 16'(state), 16'd0);
    exp_cnt = 16'd1;
    chk("luh_cnt", stall_cnt, exp_cnt);

    drive(0, 0, 0, 1, 0, 0, 0);
    #1 chk_outs("reg_zero", 5'b11000);
    @(negedge clk);
    #1 chk("reg_zero_cnt", stall_cnt, exp_cnt);
    drive(3, 4, 7, 1, 0, 0, 0);
    #1 chk_outs("no_match", 5'b11000);
    @(negedge clk);
    drive(1, 9, 9, 0, 0, 0, 0);
    #1 chk_outs("no_memread", 5'b11000);
    @(negedge clk);
    drive(1, 9, 9, 1, 0, 0, 0);
    #1 chk_outs("luh_rt", 5'b00010);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1 chk("luh_rt_state", 16'(state), 16'd1);
    chk_outs("luh_rt_c2", 5'b11000);
    @(negedge clk);
    exp_cnt = 16'd2;
    #1 chk("luh_rt_cnt", stall_cnt, exp_cnt);

    // miss with ack after three wait cycles
    drive(0, 0, 0, 0, 0, 1, 0);
    #1 chk_outs("miss_run", 5'b00001);
    @(negedge clk);
    #1 chk("miss_state", 16'(state), 16'd2);
    chk_outs("wait1", 5'b00001);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1 chk_outs("wait_ignore_req", 5'b00001);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1, 0);
    #1 chk_outs("wait3", 5'b00001);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1, 1);
    #1 chk_outs("wait_ack", 5'b11000);
    chk("wait_ack_state", 16'(state), 16'd2);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    exp_cnt = 16'd6;
    #1 chk("miss_back", 16'(state), 16'd0);
    chk("miss_cnt", stall_cnt, exp_cnt);

    drive(0, 0, 0, 0, 0, 1, 1);
    #1 chk_outs("req_ack_hit", 5'b11000);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 0, 0);
    #1 chk("hit_state", 16'(state), 16'd0);
    chk_outs("branch_flush", 5'b11100);
    @(negedge clk);
    #1 chk("branch_state", 16'(state), 16'd0);

    // miss outranks load-use and branch
    drive(5, 0, 5, 1, 1, 1, 0);
    #1 chk_outs("miss_priority", 5'b00001);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1, 1);
    #1 chk("priority_state", 16'(state), 16'd2);
    chk_outs("priority_ack", 5'b11000);
    @(negedge clk);

    // miss while in LOAD_STALL
    drive(5, 0, 5, 1, 0, 0, 0);
    #1 chk_outs("ls_luh", 5'b00010);
    @(negedge clk);
    drive(5, 0, 5, 1, 0, 1, 0);
    #1 chk_outs("ls_miss", 5'b00001);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1, 1);
    #1 chk("ls_miss_state", 16'(state), 16'd2);
    @(negedge clk);
    exp_cnt = 16'd9;
    #1 chk("ls_cnt", stall_cnt, exp_cnt);

    // load-use and branch together; branch retried from LOAD_STALL
    drive(6, 0, 6, 1, 1, 0, 0);
    #1 chk_outs("luh_branch", 5'b00010);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 0, 0);
    #1 chk_outs("branch_retry", 5'b11100);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    exp_cnt = 16'd10;
    #1 chk("retry_cnt", stall_cnt, exp_cnt);

    // long miss: timeout after 255 wait cycles, then async reset mid-wait
    drive(0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    for (int k = 1; k < 300; k++) begin
      #1;
      if (k == 255) chk("timeout_early", 16'(timeout), 16'd0);
      if (k == 256) chk("timeout_set", 16'(timeout), 16'd1);
      @(negedge clk);
    end
    exp_cnt = 16'd310;
    #1 chk("timeout_hold", 16'(timeout), 16'd1);
    chk("timeout_state", 16'(state), 16'd2);
    chk("pre_reset_cnt", stall_cnt, exp_cnt);
    #1 rst = 1'b1;
    #1 chk("async_state", 16'(state), 16'd0);
    chk("async_timeout", 16'(timeout), 16'd0);
    chk("async_cnt", stall_cnt, 16'd0);
    chk_outs("async_run_outs", 5'b00001);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(8, 0, 8, 1, 0, 0, 0);
    #1 chk_outs("post_reset_luh", 5'b00010);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1 chk("post_reset_state", 16'(state), 16'd1);
    @(negedge clk);
    #1 chk("post_reset_cnt", stall_cnt, 16'd1);

    // saturation of the stall counter
    drive(0, 0, 0, 0, 0, 1, 0);
    repeat (65540) @(negedge clk);
    #1 chk("sat_cnt", stall_cnt, 16'hFFFF);
    @(negedge clk);
    #1 chk("sat_hold", stall_cnt, 16'hFFFF);
    drive(0, 0, 0, 0, 0, 1, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1 chk("sat_final_state", 16'(state), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
